// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// i2s_pkg : shared types and constants for the I2S receive path
// Rev 1.0
// ============================================================================
package i2s_pkg;

    localparam int   DEFAULT_DATA_WIDTH = 24;
    localparam logic LRCLK_LEFT         = 1'b0;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] left;
        logic [DEFAULT_DATA_WIDTH-1:0] right;
    } stereo_frame_t;

endpackage
`default_nettype wire

// File: rtl/i2s_rx_sample_fifo.sv
`default_nettype none
// ============================================================================
// sample_fifo : synchronous stereo-frame FIFO, count-based full/empty
// Rev 1.0
// ============================================================================
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type frame_t = stereo_frame_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  frame_t push_data,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output frame_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    frame_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;
    logic               w_push;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push = push && (!full || w_pop);
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_rx.sv
`default_nettype none
// ============================================================================
// i2s_rx : I2S deserializer delivering stereo frames through a small FIFO
// Rev 1.0
// ============================================================================
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SCLK,
    input  logic                  LRCLK,
    input  logic                  Din,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  overflow,
    input  logic                  clear_overflow,
    output logic [15:0]           frame_count
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } frame_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sclk_prev;
    logic                   r_rise;
    logic                   r_lr_smp;
    logic                   r_din_smp;

    rx_state_t              r_state;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [IDX_W-1:0]       r_idx;
    logic [DATA_WIDTH-1:0]  r_left_hold;
    logic                   r_lr_prev;
    logic                   r_push;
    frame_t                 r_push_frame;
    logic                   r_overflow;
    logic [15:0]            r_frame_count;

    logic [DATA_WIDTH-1:0]  w_word;
    logic [IDX_W-1:0]       w_idx_next;
    logic                   w_lr_fall;
    logic                   w_lr_rise;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_drop;
    frame_t                 w_head;

    // The rise pulse is registered together with the LRCLK/Din samples it qualifies
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_sclk_sync <= '0;
            r_lr_sync   <= '0;
            r_din_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_rise      <= 1'b0;
            r_lr_smp    <= 1'b0;
            r_din_smp   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], LRCLK};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], Din};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_rise      <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
            r_lr_smp    <= r_lr_sync[SYNC_STAGES-1];
            r_din_smp   <= r_din_sync[SYNC_STAGES-1];
        end
    end

    assign w_lr_fall  = (r_lr_prev != LRCLK_LEFT) && (r_lr_smp == LRCLK_LEFT);
    assign w_lr_rise  = (r_lr_prev == LRCLK_LEFT) && (r_lr_smp != LRCLK_LEFT);
    assign w_idx_next = (r_idx == IDX_W'(DATA_WIDTH)) ? r_idx : r_idx + 1'b1;

    // Bits past DATA_WIDTH match no position and fall away
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_idx == IDX_W'(DATA_WIDTH - 1 - i)) begin
                w_word[i] = r_din_smp;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state      <= SYNC_WAIT;
            r_shift      <= '0;
            r_idx        <= '0;
            r_left_hold  <= '0;
            r_lr_prev    <= LRCLK_LEFT;
            r_push       <= 1'b0;
            r_push_frame <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_rise) begin
                r_lr_prev <= r_lr_smp;
                case (r_state)
                    SYNC_WAIT: begin
                        if (w_lr_fall) begin
                            r_shift <= '0;
                            r_idx   <= '0;
                            r_state <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (w_lr_rise) begin
                            r_left_hold <= w_word;
                            r_shift     <= '0;
                            r_idx       <= '0;
                            r_state     <= RIGHT;
                        end else begin
                            r_shift <= w_word;
                            r_idx   <= w_idx_next;
                        end
                    end
                    RIGHT: begin
                        if (w_lr_fall) begin
                            r_push             <= 1'b1;
                            r_push_frame.left  <= r_left_hold;
                            r_push_frame.right <= w_word;
                            r_shift            <= '0;
                            r_idx              <= '0;
                            r_state            <= LEFT;
                        end else begin
                            r_shift <= w_word;
                            r_idx   <= w_idx_next;
                        end
                    end
                    default: r_state <= SYNC_WAIT;
                endcase
            end
        end
    end

    sample_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .frame_t (frame_t)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (r_push),
        .push_data (r_push_frame),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign w_pop  = !w_empty && sample_ready;
    assign w_drop = r_push && w_full && !w_pop;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_overflow    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
            if (r_push && !w_drop) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign left_data    = w_head.left;
    assign right_data   = w_head.right;
    assign sample_valid = !w_empty;
    assign overflow     = r_overflow;
    assign frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx.sv
`default_nettype none
// ============================================================================
// tb_i2s_rx : scoreboard bench driving an I2S stream into i2s_rx
// Rev 1.0
// ============================================================================
module tb_i2s_rx;

    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          SCLK = 1'b0;
    logic          LRCLK = 1'b0;
    logic          Din = 1'b0;
    logic          sample_ready = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          overflow;
    logic [15:0]   frame_count;

    int            checks = 0;
    int            errors = 0;
    int            extra_pops = 0;
    logic [47:0]   sb [$];
    logic          m_prev_lr = 1'b0;
    logic          carry = 1'b0;
    logic          pend_valid = 1'b0;
    logic          pop_coincident = 1'b0;
    logic [47:0]   pend = '0;
    int            exp_count = 0;
    logic          exp_ovf = 1'b0;

    always #5 CLK = ~CLK;

    i2s_rx #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SCLK           (SCLK),
        .LRCLK          (LRCLK),
        .Din            (Din),
        .left_data      (left_data),
        .right_data     (right_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .frame_count    (frame_count)
    );

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic bitj(input logic [DW-1:0] w, input int j);
        logic b;
        b = (j < DW) ? w[DW-1-j] : 1'b0;
        return b;
    endfunction

    // Only the first nbits of a word reach the receiver; the rest read as zero
    function automatic logic [DW-1:0] trunc(input logic [DW-1:0] w, input int nbits);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < DW; i++) begin
            if (i < nbits) m[DW-1-i] = 1'b1;
        end
        return w & m;
    endfunction

    task automatic complete_pending();
        pend_valid = 1'b0;
        if (sb.size() < DEPTH || pop_coincident) begin
            sb.push_back(pend);
            exp_count++;
        end else begin
            exp_ovf = 1'b1;
        end
    endtask

    // One SCLK period of 16 CLK; LRCLK/Din change with the falling SCLK
    task automatic sclk_cycle(input logic lr, input logic d);
        @(negedge CLK);
        SCLK = 1'b0; LRCLK = lr; Din = d;
        repeat (8) @(negedge CLK);
        SCLK = 1'b1;
        if (m_prev_lr && !lr && pend_valid) complete_pending();
        m_prev_lr = lr;
        repeat (7) @(negedge CLK);
    endtask

    task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int n);
        for (int k = 0; k < n; k++) begin
            sclk_cycle(lr, (k == 0) ? carry : bitj(w, k - 1));
        end
        carry = bitj(w, n - 1);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int n);
        logic ok;
        ok = m_prev_lr;
        send_slot(1'b0, l, n);
        send_slot(1'b1, r, n);
        if (ok) begin
            pend = {trunc(l, n), trunc(r, n)};
            pend_valid = 1'b1;
        end
    endtask

    task automatic preamble();
        send_slot(1'b1, 24'h0, 3);
    endtask

    task automatic tail();
        sclk_cycle(1'b0, carry);
        sclk_cycle(1'b0, 1'b0);
        carry = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic set_ready(input logic v);
        @(posedge CLK);
        #1 sample_ready = v;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESET = 1'b0; SCLK = 1'b0; LRCLK = 1'b0; Din = 1'b0;
        repeat (4) @(negedge CLK);
        m_prev_lr = 1'b0; pend_valid = 1'b0; carry = 1'b0;
        sb.delete(); exp_count = 0; exp_ovf = 1'b0; pop_coincident = 1'b0;
        check_eq({tag, "_valid"}, 48'(sample_valid), 48'd0);
        check_eq({tag, "_data"}, {left_data, right_data}, 48'd0);
        check_eq({tag, "_ovf"}, 48'(overflow), 48'd0);
        check_eq({tag, "_count"}, 48'(frame_count), 48'd0);
        RESET = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"}, 48'(frame_count), 48'(exp_count));
        check_eq({tag, "_ovf"}, 48'(overflow), 48'(exp_ovf));
    endtask

    task automatic drain(input string tag);
        set_ready(1'b1);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
        end
        repeat (3) @(negedge CLK);
        check_eq({tag, "_sb_left"}, 48'(sb.size()), 48'd0);
        check_eq({tag, "_valid_after"}, 48'(sample_valid), 48'd0);
        check_eq({tag, "_data_empty"}, {left_data, right_data}, 48'd0);
        check_eq({tag, "_extra_pops"}, 48'(extra_pops), 48'd0);
    endtask

    always @(negedge CLK) begin
        if (RESET && sample_valid && sample_ready) begin
            if (sb.size() == 0) extra_pops++;
            else check_eq("frame", {left_data, right_data}, sb.pop_front());
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] l, r;

        do_reset("reset");

        // Basic frame
        set_ready(1'b1);
        preamble();
        send_frame(24'hA5A5A5, 24'h123456, 32);
        tail();
        check_state("basic");
        drain("basic");

        // Start-up mid-right-slot
        do_reset("rst_align");
        set_ready(1'b1);
        send_slot(1'b1, 24'h7E7E7E, 12);
        send_frame(24'h0F1E2D, 24'h3C4B5A, 32);
        send_frame(24'h800001, 24'hFFFFFE, 32);
        tail();
        check_state("align");
        drain("align");

        // Short 16-bit words
        do_reset("rst_short");
        set_ready(1'b1);
        preamble();
        send_frame(24'hFFFFFF, 24'h5A5AFF, 16);
        send_frame(24'h8001C3, 24'h7FFE3C, 16);
        tail();
        check_state("short");
        drain("short");

        // Overflow with sample_ready held low
        do_reset("rst_ovf");
        set_ready(1'b0);
        preamble();
        for (int f = 0; f < 6; f++) begin
            l = 24'($urandom());
            r = 24'($urandom());
            send_frame(l, r, 32);
        end
        tail();
        check_state("ovf");
        check_eq("ovf_head", {left_data, right_data}, sb[0]);
        repeat (5) @(negedge CLK);
        check_eq("ovf_head_hold", {left_data, right_data}, sb[0]);
        @(posedge CLK); #1 clear_overflow = 1'b1;
        @(posedge CLK); #1 clear_overflow = 1'b0;
        exp_ovf = 1'b0;
        @(negedge CLK);
        check_state("ovf_clear");
        drain("ovf");

        // Full FIFO with a pop in the push cycle
        do_reset("rst_fullpop");
        set_ready(1'b0);
        preamble();
        for (int f = 0; f < 5; f++) begin
            l = 24'($urandom());
            r = 24'($urandom());
            send_frame(l, r, 32);
        end
        pop_coincident = 1'b1;
        fork
            tail();
            begin
                @(posedge SCLK);
                repeat (4) @(posedge CLK);
                #1 sample_ready = 1'b1;
                @(posedge CLK);
                #1 sample_ready = 1'b0;
            end
        join
        pop_coincident = 1'b0;
        check_state("fullpop");
        drain("fullpop");

        // Reset during bit 10 of a left slot
        do_reset("rst_mid");
        set_ready(1'b0);
        preamble();
        send_frame(24'h135790, 24'h2468AC, 32);
        send_slot(1'b0, 24'hABCDEF, 10);
        check_state("mid_pre");
        do_reset("mid_reset");
        set_ready(1'b1);
        send_slot(1'b0, 24'h55AA55, 14);
        send_slot(1'b1, 24'hC0FFEE, 32);
        send_frame(24'h9ABCDE, 24'h012345, 32);
        tail();
        check_state("mid_post");
        drain("mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
